// File: rtl/imm_pkg.sv
// Immediate format codes and legal range limits.
// Shared by the encoder and the immediate extender.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  localparam int signed IS_MIN = -2048;
  localparam int signed IS_MAX = 2047;
  localparam int signed B_MIN  = -4096;
  localparam int signed B_MAX  = 4094;
  localparam int signed J_MIN  = -1048576;
  localparam int signed J_MAX  = 1048574;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder.
// master drives requests and Ready_i, slave is the encoder.
interface imm_encoder_if #(
  parameter int DATAWIDTH = 32
);

  logic [2:0]           ImmSrc_i;
  logic [DATAWIDTH-1:0] Imm_i;
  logic [DATAWIDTH-1:0] Base_i;
  logic                 Valid_i;
  logic                 Ready_o;
  logic [DATAWIDTH-1:0] Instr_o;
  logic                 Err_o;
  logic                 Valid_o;
  logic                 Ready_i;

  modport master (
    output ImmSrc_i, Imm_i, Base_i,
    output Valid_i, Ready_i,
    input  Ready_o, Instr_o,
    input  Err_o, Valid_o
  );

  modport slave (
    input  ImmSrc_i, Imm_i, Base_i,
    input  Valid_i, Ready_i,
    output Ready_o, Instr_o,
    output Err_o, Valid_o
  );

endinterface

// File: rtl/imm_range_check.sv
// Flags immediates that do not fit the format,
// are misaligned, or use an illegal format code.
module imm_range_check
  import imm_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic [2:0]           src,
  input  logic [DATAWIDTH-1:0] imm,
  output logic                 err
);

  logic signed [DATAWIDTH-1:0] simm;

  assign simm = $signed(imm);

  // per-format range and alignment test
  always_comb begin
    err = 1'b1;
    unique case (1'b1)
      (src == IMM_I),
      (src == IMM_S):
        err = (simm < IS_MIN) || (simm > IS_MAX);
      (src == IMM_B):
        err = (simm < B_MIN) || (simm > B_MAX)
              || imm[0];
      (src == IMM_U):
        err = |imm[11:0];
      (src == IMM_J):
        err = (simm < J_MIN) || (simm > J_MAX)
              || imm[0];
      default:
        err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate packer: S1 latches request and
// range flag, S2 holds the packed instruction.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  imm_encoder_if.slave bus,
  output logic [15:0] EncCount_o,
  output logic [7:0]  ErrCount_o
);

  logic                 s1_valid;
  logic [2:0]           s1_src;
  logic [DATAWIDTH-1:0] s1_imm;
  logic [DATAWIDTH-1:0] s1_base;
  logic                 s1_err;

  logic                 s2_valid;
  logic [DATAWIDTH-1:0] s2_instr;
  logic                 s2_err;

  logic                 chk_err;
  logic [DATAWIDTH-1:0] packed_instr;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 s2_load;
  logic                 ready;

  imm_range_check #(
    .DATAWIDTH (DATAWIDTH)
  ) u_range (
    .src (bus.ImmSrc_i),
    .imm (bus.Imm_i),
    .err (chk_err)
  );

  assign out_xfer = s2_valid && bus.Ready_i;
  assign s2_load  = s1_valid
                    && (!s2_valid || bus.Ready_i);
  assign ready    = !s1_valid || s2_load;
  assign in_xfer  = bus.Valid_i && ready;

  assign bus.Ready_o = ready;
  assign bus.Valid_o = s2_valid;
  assign bus.Instr_o = s2_instr;
  assign bus.Err_o   = s2_err;

  // stage 1: capture request and its range flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_src   <= bus.ImmSrc_i;
      s1_imm   <= bus.Imm_i;
      s1_base  <= bus.Base_i;
      s1_err   <= chk_err;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // scatter immediate bits into the base word
  always_comb begin
    packed_instr = s1_base;
    unique case (1'b1)
      (s1_src == IMM_I): begin
        packed_instr[31:20] = s1_imm[11:0];
      end
      (s1_src == IMM_S): begin
        packed_instr[31:25] = s1_imm[11:5];
        packed_instr[11:7]  = s1_imm[4:0];
      end
      (s1_src == IMM_B): begin
        packed_instr[31]    = s1_imm[12];
        packed_instr[7]     = s1_imm[11];
        packed_instr[30:25] = s1_imm[10:5];
        packed_instr[11:8]  = s1_imm[4:1];
      end
      (s1_src == IMM_U): begin
        packed_instr[31:12] = s1_imm[31:12];
      end
      (s1_src == IMM_J): begin
        packed_instr[31]    = s1_imm[20];
        packed_instr[30:21] = s1_imm[10:1];
        packed_instr[20]    = s1_imm[11];
        packed_instr[19:12] = s1_imm[19:12];
      end
      default: begin
        packed_instr = s1_base;
      end
    endcase
  end

  // stage 2: hold result until downstream takes it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_instr <= packed_instr;
      s2_err   <= s1_err;
    end else if (out_xfer) begin
      s2_valid <= 1'b0;
    end
  end

  // count completed transfers and errored ones
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      EncCount_o <= '0;
      ErrCount_o <= '0;
    end else if (out_xfer) begin
      EncCount_o <= EncCount_o + 16'd1;
      if (s2_err && (ErrCount_o != 8'hFF))
        ErrCount_o <= ErrCount_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: reference model, scoreboard,
// directed literal vectors.
module tb_imm_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] enc;
  logic [7:0]  errc;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  int cyc = 0;

  exp_t q[$];
  int   m_enc = 0;
  int   m_err = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  imm_encoder_if #(.DATAWIDTH(32)) bus ();

  imm_encoder #(.DATAWIDTH(32)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .bus        (bus),
    .EncCount_o (enc),
    .ErrCount_o (errc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40)
        $display("FAIL %s: got %h, expected %h",
                 nm, act, exp);
      n_print++;
    end
  endtask

  function automatic exp_t model(input logic [2:0] s,
                                 input logic [31:0] im,
                                 input logic [31:0] b);
    exp_t r;
    int signed v;
    v = $signed(im);
    case (s)
      3'd0: begin
        r.instr = (b & 32'h000FFFFF)
                | ((im & 32'hFFF) << 20);
        r.err = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        r.instr = (b & 32'h01FFF07F)
                | (((im >> 5) & 32'h7F) << 25)
                | ((im & 32'h1F) << 7);
        r.err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        r.instr = (b & 32'h01FFF07F)
                | (((im >> 12) & 32'h1) << 31)
                | (((im >> 11) & 32'h1) << 7)
                | (((im >> 5) & 32'h3F) << 25)
                | (((im >> 1) & 32'hF) << 8);
        r.err = (v < -4096) || (v > 4094)
              || ((im & 32'h1) != 0);
      end
      3'd3: begin
        r.instr = (b & 32'hFFF)
                | (im & 32'hFFFFF000);
        r.err = (im & 32'hFFF) != 0;
      end
      3'd4: begin
        r.instr = (b & 32'hFFF)
                | (((im >> 20) & 32'h1) << 31)
                | (((im >> 1) & 32'h3FF) << 21)
                | (((im >> 11) & 32'h1) << 20)
                | (im & 32'h000FF000);
        r.err = (v < -1048576) || (v > 1048574)
              || ((im & 32'h1) != 0);
      end
      default: begin
        r.instr = b;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

  // scoreboard: counters, stall stability, ordering
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
      stall_prev = 1'b0;
    end else begin
      chk("enc_count", 32'(enc), 32'(m_enc % 65536));
      chk("err_count", 32'(errc),
          32'((m_err > 255) ? 255 : m_err));
      if (stall_prev) begin
        chk("stall_valid", 32'(bus.Valid_o), 32'd1);
        chk("stall_instr", bus.Instr_o, prev_instr);
        chk("stall_err", 32'(bus.Err_o), 32'(prev_err));
      end
      if (bus.Valid_o && bus.Ready_i) begin
        if (q.size() == 0) begin
          chk("stale_out", 32'(bus.Valid_o), 32'd0);
        end else begin
          e = q.pop_front();
          chk("instr", bus.Instr_o, e.instr);
          chk("err", 32'(bus.Err_o), 32'(e.err));
          m_enc++;
          if (e.err && m_err < 1000) m_err++;
        end
      end
      stall_prev = bus.Valid_o && !bus.Ready_i;
      prev_instr = bus.Instr_o;
      prev_err = bus.Err_o;
      if (bus.Valid_i && bus.Ready_o)
        q.push_back(model(bus.ImmSrc_i, bus.Imm_i,
                          bus.Base_i));
    end
  end

  task automatic send(input logic [2:0] s,
                      input logic [31:0] im,
                      input logic [31:0] b);
    int n = 0;
    bus.ImmSrc_i = s;
    bus.Imm_i = im;
    bus.Base_i = b;
    bus.Valid_i = 1'b1;
    @(negedge clk);
    while (!bus.Ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.Ready_o)
      chk("send_timeout", 32'(bus.Ready_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || bus.Valid_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100)
      chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm,
                     input logic [2:0] s,
                     input logic [31:0] im,
                     input logic [31:0] b,
                     input logic [31:0] ei,
                     input logic ee);
    int n = 0;
    send(s, im, b);
    idle();
    @(negedge clk);
    while (!bus.Valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 32'(bus.Valid_o), 32'd1);
    chk({nm, "_instr"}, bus.Instr_o, ei);
    chk({nm, "_err"}, 32'(bus.Err_o), 32'(ee));
    drain();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [31:0] held;
    bus.ImmSrc_i = '0;
    bus.Imm_i = '0;
    bus.Base_i = '0;
    bus.Valid_i = 1'b0;
    bus.Ready_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_ready", 32'(bus.Ready_o), 32'd1);
    chk("rst_valid", 32'(bus.Valid_o), 32'd0);
    chk("rst_instr", bus.Instr_o, 32'h0);
    chk("rst_err", 32'(bus.Err_o), 32'd0);
    chk("rst_enc", 32'(enc), 32'd0);
    chk("rst_errc", 32'(errc), 32'd0);
    @(posedge clk);
    #1;

    send(3'd0, 32'hFFFFFFFF, 32'h00000093);
    idle();
    @(negedge clk);
    chk("lat1_valid", 32'(bus.Valid_o), 32'd0);
    @(negedge clk);
    chk("lat2_valid", 32'(bus.Valid_o), 32'd1);
    chk("lat2_instr", bus.Instr_o, 32'hFFF00093);
    chk("lat2_err", 32'(bus.Err_o), 32'd0);
    drain();

    lit("s8", 3'd1, 32'd8, 32'h0020A023,
        32'h0020A423, 1'b0);
    lit("bm4", 3'd2, 32'hFFFFFFFC, 32'h00000063,
        32'hFE000EE3, 1'b0);
    lit("u", 3'd3, 32'h12345000, 32'h00000037,
        32'h12345037, 1'b0);
    lit("j2048", 3'd4, 32'h00000800, 32'h0000006F,
        32'h0010006F, 1'b0);
    lit("jm2", 3'd4, 32'hFFFFFFFE, 32'h0000006F,
        32'hFFFFF06F, 1'b0);
    lit("i2048", 3'd0, 32'd2048, 32'h00000093,
        32'h80000093, 1'b1);
    chk("errc_one", 32'(errc), 32'd1);
    lit("b3", 3'd2, 32'd3, 32'h00000063,
        32'h00000163, 1'b1);
    lit("ill", 3'd7, 32'h00000ABC, 32'h12345678,
        32'h12345678, 1'b1);
    lit("u_low", 3'd3, 32'h12345001, 32'h00000037,
        32'h12345037, 1'b1);

    t0 = cyc;
    send(3'd0, 32'd2047, 32'h13);
    send(3'd0, -32'sd2048, 32'h13);
    send(3'd0, -32'sd2049, 32'h13);
    send(3'd1, 32'd2048, 32'h23);
    send(3'd1, -32'sd2048, 32'h23);
    send(3'd2, 32'd4094, 32'h63);
    send(3'd2, -32'sd4096, 32'h63);
    send(3'd2, 32'd4096, 32'h63);
    send(3'd2, -32'sd4098, 32'h63);
    send(3'd4, 32'd1048574, 32'h6F);
    send(3'd4, -32'sd1048576, 32'h6F);
    send(3'd4, 32'd1048576, 32'h6F);
    send(3'd4, 32'd3, 32'h6F);
    send(3'd5, 32'd4, 32'hCAFEF00D);
    chk("throughput", 32'(cyc - t0), 32'd14);
    idle();
    drain();

    bus.Ready_i = 1'b0;
    send(3'd0, 32'd1, 32'h00000013);
    send(3'd0, 32'd2, 32'h00000013);
    bus.ImmSrc_i = 3'd0;
    bus.Imm_i = 32'd3;
    @(negedge clk);
    chk("bp_ready1", 32'(bus.Ready_o), 32'd0);
    held = bus.Instr_o;
    @(negedge clk);
    chk("bp_ready2", 32'(bus.Ready_o), 32'd0);
    chk("bp_hold", bus.Instr_o, held);
    chk("bp_head", bus.Instr_o, 32'h00100013);
    @(posedge clk);
    #1 bus.Ready_i = 1'b1;
    send(3'd0, 32'd3, 32'h00000013);
    send(3'd0, 32'd4, 32'h00000013);
    idle();
    drain();

    fork
      begin
        for (int i = 0; i < 24; i++)
          send(3'(i % 6),
               32'(i * i * 131 - 2000) << (i % 4),
               32'h10000000 + 32'(i) * 32'h1111);
        idle();
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #1 bus.Ready_i = (k % 3) != 2;
        end
      end
    join
    bus.Ready_i = 1'b1;
    drain();

    bus.Ready_i = 1'b0;
    send(3'd0, 32'd5, 32'h13);
    send(3'd7, 32'd6, 32'h13);
    idle();
    @(negedge clk);
    chk("full_ready", 32'(bus.Ready_o), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rr_valid", 32'(bus.Valid_o), 32'd0);
    chk("rr_enc", 32'(enc), 32'd0);
    chk("rr_errc", 32'(errc), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.Ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_nostale", 32'(bus.Valid_o), 32'd0);
    end
    chk("rr_ready", 32'(bus.Ready_o), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++)
      send(3'd7, 32'(i), 32'(i));
    for (int i = 0; i < 65237; i++)
      send(3'd0, 32'(i) & 32'h7FF, 32'h13);
    idle();
    drain();
    chk("enc_wrap", 32'(enc), 32'h0001);
    chk("errc_sat", 32'(errc), 32'h00FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter DATAWIDTH, default 32, instruction/immediate width; only 32 is supported.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset; asynchronous assert, active-low.
REQ-004 ImmSrc_i  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal.
REQ-005 Imm_i  input  DATAWIDTH  sign-extended immediate value to place.
REQ-006 Base_i  input  DATAWIDTH  instruction word whose non-immediate bits are kept.
REQ-007 Valid_i  input  1  upstream request valid.
REQ-008 Ready_o  output  1  encoder can accept a request this cycle.
REQ-009 Instr_o  output  DATAWIDTH  encoded instruction.
REQ-010 Err_o  output  1  immediate out of range, misaligned, or format illegal; qualified by Valid_o.
REQ-011 Valid_o  output  1  Instr_o/Err_o valid.
REQ-012 Ready_i  input  1  downstream accepts output this cycle.
REQ-013 EncCount_o  output  16  completed transfers, wraps at 0xFFFF->0.
REQ-014 ErrCount_o  output  8  completed transfers with Err_o=1, saturates at 0xFF.

Function
REQ-015 Input transfer occurs when Valid_i && Ready_o; output transfer when Valid_o && Ready_i.
REQ-016 Two register stages: S1 captures inputs and computes range check; S2 holds packed result.
REQ-017 Latency from input transfer to Valid_o SHALL be exactly 2 cycles when not stalled.
REQ-018 Throughput one transfer per cycle when Ready_i is held high.
REQ-019 S2 loads when empty or being drained; S1 advances when S2 loads; Ready_o = !S1valid || S1 advancing.
REQ-020 While Valid_o && !Ready_i, Instr_o, Err_o, Valid_o SHALL hold stable.
REQ-021 Packing: I -> Instr[31:20]=Imm[11:0].
REQ-022 S -> Instr[31:25]=Imm[11:5], Instr[11:7]=Imm[4:0].
REQ-023 B -> Instr[31]=Imm[12], [7]=Imm[11], [30:25]=Imm[10:5], [11:8]=Imm[4:1].
REQ-024 U -> Instr[31:12]=Imm[31:12].
REQ-025 J -> Instr[31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12].
REQ-026 All bits not named for the format SHALL equal Base_i.
REQ-027 Legal ranges: I/S -2048..2047; B -4096..4094 and Imm[0]=0; U Imm[11:0]=0; J -1048576..1048574 and Imm[0]=0.
REQ-028 Violation sets Err_o=1; Instr_o still carries the truncated packing of REQ-021..025.
REQ-029 Illegal ImmSrc_i sets Err_o=1 and Instr_o=Base_i.
REQ-030 Counters increment on output transfer only; both updated in the same cycle when Err_o=1.
REQ-031 Simultaneous input and output transfer with both stages full SHALL lose no request.

Reset
REQ-032 rst_n_i low: S1/S2 valid=0, Instr_o=0, Err_o=0, Valid_o=0, EncCount_o=0, ErrCount_o=0, Ready_o=1 from the first cycle after deassertion.
REQ-033 Reset mid-operation discards in-flight requests; no output transfer is counted for them.

Structure
REQ-034 Package imm_pkg holds the ImmSrc enum (shared with the immediate extender) and range limit constants.
REQ-035 Sub-module imm_range_check (combinational) computes the Err flag from ImmSrc and Imm.

Verification
REQ-036 I: Base 0x00000093, Imm 0xFFFFFFFF, ImmSrc 000 -> Instr_o 0xFFF00093, Err_o 0, Valid_o 2 cycles later.
REQ-037 S: Base 0x0020A023, Imm 8, ImmSrc 001 -> Instr_o 0x0020A423; B: Base 0x00000063, Imm 0xFFFFFFFC, ImmSrc 010 -> 0xFE000EE3.
REQ-038 Errors: I Imm 2048 -> Err_o 1, ErrCount_o 1; B Imm 3 -> Err_o 1; ImmSrc 111 -> Instr_o=Base_i, Err_o 1.
REQ-039 Backpressure: stream 4 requests, Ready_i low 3 cycles -> Instr_o stable, Ready_o low after 2 accepted, all 4 emerge in order.
REQ-040 Counters: 65537 transfers -> EncCount_o 1; 300 errored -> ErrCount_o 0xFF.
REQ-041 Reset with both stages full -> Valid_o 0 next cycle, counters 0, no stale output after release.
